// File: rtl/led_sweep_if.sv
// rtl/led_sweep_if.sv - LED sample bus (strobe + 8-bit pattern) between source and decoder
//
// Signals:
//   valid : sample strobe, the pattern is evaluated only when high
//   led   : observed 8-bit LED pattern
// Modports:
//   master : pattern source (drives valid/led)
//   slave  : decoder (observes valid/led)

interface led_sweep_if;
    logic       valid;
    logic [7:0] led;

    modport master (output valid, output led);
    modport slave  (input  valid, input  led);
endinterface

// File: rtl/led_sweep_decoder.sv
// rtl/led_sweep_decoder.sv - receive-side lock/error checker for the 14-phase bouncing LED sweep
//
// Ports:
//   i_clk         : clock, all state updates on posedge
//   i_reset_n     : synchronous reset, active low
//   bus           : led_sweep_if.slave (valid strobe + 8-bit led pattern)
//   o_index       : recovered phase 1..14, 0 = start/unknown
//   o_dir         : 0 = moving toward bit7, 1 = moving toward bit0
//   o_locked      : high while locked onto a clean sequence
//   o_error       : one-cycle pulse on a broken step while locked
//   o_err_count   : saturating count of error pulses
//   o_sweep_count : saturating count of 14->1 wraps seen while locked

module led_sweep_decoder #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    led_sweep_if.slave       bus,
    output logic [3:0]       o_index,
    output logic             o_dir,
    output logic             o_locked,
    output logic             o_error,
    output logic [ERR_W-1:0] o_err_count,
    output logic [ERR_W-1:0] o_sweep_count
);

    localparam logic [0:0] S_SEARCH = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    localparam logic [3:0]       LOCK_TH = 4'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] SAT     = {ERR_W{1'b1}};

    logic [0:0] state;
    logic [3:0] streak;
    logic [7:0] prev_led;

    logic [7:0] cur_led;
    logic       cur_onehot;
    logic       prev_onehot;
    logic [2:0] cur_pos;
    logic [2:0] prev_pos;
    logic       start_step;
    logic       move_up;
    logic       move_down;
    logic       trans_ok;
    logic [3:0] move_phase;
    logic       move_dir;
    logic [3:0] streak_inc;
    logic [3:0] succ;
    logic [7:0] exp_led;

    assign cur_led     = bus.led;
    assign cur_onehot  = (cur_led != 8'h00) && ((cur_led & (cur_led - 8'h01)) == 8'h00);
    assign prev_onehot = (prev_led != 8'h00) && ((prev_led & (prev_led - 8'h01)) == 8'h00);

    always_comb begin
        cur_pos  = 3'd0;
        prev_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cur_led[i])  cur_pos  = 3'(i);
            if (prev_led[i]) prev_pos = 3'(i);
        end
    end

    // Positions are widened so that bit7->bit0 never looks like an adjacent step.
    assign start_step = (prev_led == 8'h00) && (cur_led == 8'h01);
    assign move_up    = cur_onehot && prev_onehot && ({1'b0, cur_pos} == {1'b0, prev_pos} + 4'd1);
    assign move_down  = cur_onehot && prev_onehot && ({1'b0, prev_pos} == {1'b0, cur_pos} + 4'd1);
    assign trans_ok   = start_step || move_up || move_down;

    // Descending onto bit0 is the wrap back to phase 1, which counts as ascending.
    assign move_dir   = move_down && (cur_pos != 3'd0);
    assign move_phase = move_dir ? (4'd15 - {1'b0, cur_pos}) : ({1'b0, cur_pos} + 4'd1);
    assign streak_inc = streak + 4'd1;

    always_comb begin
        succ = (o_index == 4'd14) ? 4'd1 : (o_index + 4'd1);
        if (succ <= 4'd8) begin
            exp_led = 8'h01 << (succ - 4'd1);
        end else begin
            exp_led = 8'h01 << (4'd15 - succ);
        end
    end

    assign o_locked = (state == S_LOCKED);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= S_SEARCH;
            streak        <= 4'd0;
            prev_led      <= 8'h00;
            o_index       <= 4'd0;
            o_dir         <= 1'b0;
            o_error       <= 1'b0;
            o_err_count   <= '0;
            o_sweep_count <= '0;
        end else begin
            o_error <= 1'b0;
            if (bus.valid) begin
                // Every sample becomes the reference, including a bad one, so a
                // relock can start from the very sample that broke the lock.
                prev_led <= cur_led;
                if (state == S_SEARCH) begin
                    if (trans_ok) begin
                        o_index <= move_phase;
                        o_dir   <= move_dir;
                        if (streak_inc >= LOCK_TH) begin
                            state  <= S_LOCKED;
                            streak <= 4'd0;
                        end else begin
                            streak <= streak_inc;
                        end
                    end else begin
                        streak  <= 4'd0;
                        o_index <= 4'd0;
                        o_dir   <= 1'b0;
                    end
                end else begin
                    if (cur_led == exp_led) begin
                        o_index <= succ;
                        o_dir   <= (succ >= 4'd9);
                        if ((o_index == 4'd14) && (o_sweep_count != SAT)) begin
                            o_sweep_count <= o_sweep_count + 1'b1;
                        end
                    end else begin
                        o_error <= 1'b1;
                        if (o_err_count != SAT) begin
                            o_err_count <= o_err_count + 1'b1;
                        end
                        state   <= S_SEARCH;
                        streak  <= 4'd0;
                        o_index <= 4'd0;
                        o_dir   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
